// File: rtl/ysyx_22041461_mcpu.sv
// Multi-cycle RV32I/RV64I subset core: FETCH -> EXEC -> FETCH, terminal HALT on ebreak or illegal.
// Each instruction takes two cycles when instruction memory is always ready.
module ysyx_22041461_mcpu #(
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            flag,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int              IDXW    = $clog2(NREG);
  localparam logic [5:0]      NREG_L  = 6'(NREG);
  localparam logic [XLEN-1:0] PC_INIT = RESET_PC[XLEN-1:0];

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     ir_reg;
  logic            flag_reg;
  logic            illegal_reg;
  logic [XLEN-1:0] rf_reg [NREG];

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < NREG_L;
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir_reg[6:0];
  assign rd     = ir_reg[11:7];
  assign funct3 = ir_reg[14:12];
  assign rs1    = ir_reg[19:15];
  assign rs2    = ir_reg[24:20];
  assign funct7 = ir_reg[31:25];

  logic [XLEN-1:0] imm_i, imm_u, imm_j;

  assign imm_i = XLEN'(signed'(ir_reg[31:20]));
  assign imm_u = XLEN'(signed'({ir_reg[31:12], 12'b0}));
  assign imm_j = XLEN'(signed'({ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0}));

  // x0 and indices beyond the implemented file read as zero
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1_val = (rs1 != 5'd0 && idx_ok(rs1)) ? rf_reg[rs1[IDXW-1:0]] : '0;
  assign rs2_val = (rs2 != 5'd0 && idx_ok(rs2)) ? rf_reg[rs2[IDXW-1:0]] : '0;

  logic [XLEN-1:0] pc_plus4, add_i, add_r, sub_r, jal_target, jalr_target;

  assign pc_plus4    = pc_reg + XLEN'(4);
  assign add_i       = rs1_val + imm_i;
  assign add_r       = rs1_val + rs2_val;
  assign sub_r       = rs1_val - rs2_val;
  assign jal_target  = pc_reg + imm_j;
  assign jalr_target = {add_i[XLEN-1:1], 1'b0};

  logic            dec_ok;
  logic            uses_rs1, uses_rs2, uses_rd;
  logic            is_ebreak;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] pc_next;

  always_comb begin
    dec_ok    = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    uses_rd   = 1'b0;
    is_ebreak = 1'b0;
    wr_data   = '0;
    pc_next   = pc_plus4;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          dec_ok   = 1'b1;
          uses_rs1 = 1'b1;
          uses_rd  = 1'b1;
          wr_data  = add_i;
        end
      end
      OP_IMM32: begin
        if (XLEN == 64 && funct3 == 3'b000) begin
          dec_ok   = 1'b1;
          uses_rs1 = 1'b1;
          uses_rd  = 1'b1;
          wr_data  = sext_w(add_i[31:0]);
        end
      end
      OP_REG: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          dec_ok   = 1'b1;
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
          uses_rd  = 1'b1;
          wr_data  = funct7[5] ? sub_r : add_r;
        end
      end
      OP_REG32: begin
        if (XLEN == 64 && funct3 == 3'b000 &&
            (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          dec_ok   = 1'b1;
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
          uses_rd  = 1'b1;
          wr_data  = funct7[5] ? sext_w(sub_r[31:0]) : sext_w(add_r[31:0]);
        end
      end
      OP_LUI: begin
        dec_ok  = 1'b1;
        uses_rd = 1'b1;
        wr_data = imm_u;
      end
      OP_AUIPC: begin
        dec_ok  = 1'b1;
        uses_rd = 1'b1;
        wr_data = pc_reg + imm_u;
      end
      OP_JAL: begin
        // A target that is not 4-byte aligned is treated as an illegal instruction
        dec_ok  = ~jal_target[1];
        uses_rd = 1'b1;
        wr_data = pc_plus4;
        pc_next = jal_target;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec_ok   = ~jalr_target[1];
          uses_rs1 = 1'b1;
          uses_rd  = 1'b1;
          wr_data  = pc_plus4;
          pc_next  = jalr_target;
        end
      end
      OP_SYSTEM: begin
        if (ir_reg == EBREAK) begin
          dec_ok    = 1'b1;
          is_ebreak = 1'b1;
          pc_next   = pc_reg;
        end
      end
      default: begin
      end
    endcase
  end

  logic idx_bad, legal, wr_fire;

  assign idx_bad = (uses_rs1 && !idx_ok(rs1)) ||
                   (uses_rs2 && !idx_ok(rs2)) ||
                   (uses_rd  && !idx_ok(rd));
  assign legal   = dec_ok && !idx_bad;
  assign wr_fire = (state_reg == ST_EXEC) && legal && uses_rd && (rd != 5'd0);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_FETCH;
    else      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: if (imem_req && imem_ready) state_next = ST_EXEC;
      ST_EXEC:  state_next = (!legal || is_ebreak) ? ST_HALT : ST_FETCH;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req = (state_reg == ST_FETCH);
    retire   = (state_reg == ST_EXEC) && legal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg      <= PC_INIT;
      ir_reg      <= '0;
      flag_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      if (state_reg == ST_FETCH && imem_req && imem_ready) ir_reg <= imem_rdata;
      if (state_reg == ST_EXEC) begin
        if (legal) begin
          pc_reg <= pc_next;
          if (is_ebreak) flag_reg <= 1'b1;
        end else begin
          illegal_reg <= 1'b1;
        end
      end
    end
  end

  logic [NREG-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    if (wr_fire) wr_sel[rd[IDXW-1:0]] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)            rf_reg[gi] <= '0;
        else if (wr_sel[gi]) rf_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign flag      = flag_reg;
  assign illegal   = illegal_reg;
  assign dbg_rdata = (dbg_raddr != 5'd0 && idx_ok(dbg_raddr)) ? rf_reg[dbg_raddr[IDXW-1:0]] : '0;

endmodule

// File: tb/tb_ysyx_22041461_mcpu.sv
// Bench for ysyx_22041461_mcpu: directed scenarios plus a random instruction stream
// checked against an instruction-level reference model.
module tb_ysyx_22041461_mcpu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ready, retire, flag, illegal;
  logic [63:0] imem_addr, pc, dbg_rdata;
  logic [31:0] imem_rdata;
  logic [4:0]  dbg_raddr;

  logic        s_req, s_ready, s_retire, s_flag, s_illegal;
  logic [63:0] s_addr, s_pc, s_dbg_rdata;
  logic [31:0] s_rdata;
  logic [4:0]  s_dbg_raddr;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_pc;
  bit          m_flag, m_ill, m_halt;

  always #5 clk = ~clk;

  ysyx_22041461_mcpu #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .retire(retire),
    .flag(flag), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  ysyx_22041461_mcpu #(.XLEN(64), .NREG(16)) dut16 (
    .clk(clk), .rst(rst), .imem_req(s_req), .imem_addr(s_addr),
    .imem_ready(s_ready), .imem_rdata(s_rdata), .pc(s_pc), .retire(s_retire),
    .flag(s_flag), .illegal(s_illegal), .dbg_raddr(s_dbg_raddr), .dbg_rdata(s_dbg_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {f7, rs2, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_pc   = RST_PC;
    m_flag = 1'b0;
    m_ill  = 1'b0;
    m_halt = 1'b0;
  endtask

  // Architectural effect of one instruction on the model; ret tells whether it retires
  task automatic model_step(input logic [31:0] ins, output bit ret);
    logic [63:0] a, b, imm_i, imm_u, imm_j, val, npc, tgt;
    logic [31:0] w;
    logic [4:0]  rd;
    bit          ok, wr, ebrk;
    a     = m_regs[ins[19:15]];
    b     = m_regs[ins[24:20]];
    rd    = ins[11:7];
    imm_i = 64'($signed(ins[31:20]));
    imm_u = 64'($signed({ins[31:12], 12'b0}));
    imm_j = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    ok = 0; wr = 0; ebrk = 0; val = 64'd0; npc = m_pc + 64'd4;
    case (ins[6:0])
      7'h13: if (ins[14:12] == 3'd0) begin ok = 1; wr = 1; val = a + imm_i; end
      7'h1b: if (ins[14:12] == 3'd0) begin
        ok = 1; wr = 1; w = a[31:0] + imm_i[31:0]; val = 64'($signed(w));
      end
      7'h33: if (ins[14:12] == 3'd0 && ins[31:25] == 7'h00) begin ok = 1; wr = 1; val = a + b; end
             else if (ins[14:12] == 3'd0 && ins[31:25] == 7'h20) begin ok = 1; wr = 1; val = a - b; end
      7'h3b: if (ins[14:12] == 3'd0 && (ins[31:25] == 7'h00 || ins[31:25] == 7'h20)) begin
        ok = 1; wr = 1;
        w = (ins[31:25] == 7'h00) ? a[31:0] + b[31:0] : a[31:0] - b[31:0];
        val = 64'($signed(w));
      end
      7'h37: begin ok = 1; wr = 1; val = imm_u; end
      7'h17: begin ok = 1; wr = 1; val = m_pc + imm_u; end
      7'h6f: begin tgt = m_pc + imm_j; ok = !tgt[1]; wr = 1; val = m_pc + 64'd4; npc = tgt; end
      7'h67: if (ins[14:12] == 3'd0) begin
        tgt = (a + imm_i) & ~64'd1; ok = !tgt[1]; wr = 1; val = m_pc + 64'd4; npc = tgt;
      end
      7'h73: if (ins == 32'h0010_0073) begin ok = 1; ebrk = 1; npc = m_pc; end
      default: ;
    endcase
    if (!ok) begin
      m_ill = 1; m_halt = 1; ret = 0;
    end else begin
      ret = 1;
      if (wr && rd != 5'd0) m_regs[rd] = val;
      m_pc = npc;
      if (ebrk) begin m_flag = 1; m_halt = 1; end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm12;
    logic [20:0] joff;
    rd    = 5'($urandom_range(0, 7));
    rs1   = 5'($urandom_range(0, 7));
    rs2   = 5'($urandom_range(0, 7));
    imm12 = 12'($urandom);
    joff  = 21'(($urandom_range(0, 1023) - 512) * 4);
    case ($urandom_range(0, 8))
      0: return enc_i(imm12, rs1, 3'd0, rd, 7'h13);
      1: return enc_r(7'h00, rs2, rs1, rd, 7'h33);
      2: return enc_r(7'h20, rs2, rs1, rd, 7'h33);
      3: return enc_u(20'($urandom), rd, 7'h37);
      4: return enc_u(20'($urandom), rd, 7'h17);
      5: return enc_i(imm12, rs1, 3'd0, rd, 7'h1b);
      6: return enc_r(7'h00, rs2, rs1, rd, 7'h3b);
      7: return enc_r(7'h20, rs2, rs1, rd, 7'h3b);
      default: return enc_j(joff, rd);
    endcase
  endfunction

  // Called on a falling edge while the core is in FETCH; returns #1 after the next FETCH edge
  task automatic run_instr(input logic [31:0] ins, input int stall);
    bit         er;
    logic [4:0] rd;
    for (int s = 0; s <= stall; s++) begin
      check("fetch_req", 64'(imem_req), 64'd1);
      check("fetch_addr", imem_addr, m_pc);
      check("fetch_retire", 64'(retire), 64'd0);
      imem_rdata = ins;
      imem_ready = (s == stall);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    rd = ins[11:7];
    model_step(ins, er);
    check("exec_retire", 64'(retire), 64'(er));
    check("exec_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    check("pc", pc, m_pc);
    check("flag", 64'(flag), 64'(m_flag));
    check("illegal", 64'(illegal), 64'(m_ill));
    if (m_halt) check("halt_req", 64'(imem_req), 64'd0);
    dbg_raddr = rd;
    #1;
    check("rd_value", dbg_rdata, m_regs[rd]);
    $display("instr %h stall %0d retire %0b pc %h x%0d=%h", ins, stall, er, pc, rd, dbg_rdata);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    dbg_raddr = idx;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b0;
    s_ready = 1'b0;
    @(negedge clk);
    model_reset();
    check("rst_pc", pc, RST_PC);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_flag", 64'(flag), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check_reg("rst_x1", 5'd1, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  initial begin
    imem_ready  = 1'b0;
    imem_rdata  = 32'h0;
    dbg_raddr   = 5'd0;
    s_ready     = 1'b0;
    s_rdata     = 32'h0;
    s_dbg_raddr = 5'd0;
    model_reset();

    do_reset();
    // First fetch stalled three cycles, then back-to-back addi
    run_instr(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 3);
    check_reg("x1_eq5", 5'd1, 64'd5);
    run_instr(enc_i(12'hff9, 5'd1, 3'd0, 5'd2, 7'h13), 0);
    check_reg("x2_neg2", 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    check("pc_plus8", pc, RST_PC + 64'd8);

    run_instr(enc_u(20'h80000, 5'd3, 7'h37), 0);
    check_reg("lui_x3", 5'd3, 64'hFFFF_FFFF_8000_0000);
    run_instr(enc_i(12'hfff, 5'd3, 3'd0, 5'd4, 7'h1b), 1);
    check_reg("addiw_x4", 5'd4, 64'h0000_0000_7FFF_FFFF);

    // jalr with rd == rs1 must use the old rs1
    run_instr(enc_u(20'h80001, 5'd7, 7'h37), 0);
    run_instr(enc_i(12'd8, 5'd7, 3'd0, 5'd7, 7'h67), 0);
    check("jalr_same_pc", pc, 64'hFFFF_FFFF_8000_1008);

    for (int n = 0; n < 300; n++) run_instr(rand_instr(), int'($urandom_range(0, 2)));
    run_instr(enc_i(12'd0, 5'd1, 3'b011, 5'd2, 7'h03), 0);
    check("ld_illegal", 64'(illegal), 64'd1);

    do_reset();
    run_instr(enc_j(21'd16, 5'd1), 0);
    check("jal_addr", imem_addr, 64'h8000_0010);
    check_reg("jal_x1", 5'd1, 64'h8000_0004);
    run_instr(enc_i(12'd2, 5'd1, 3'd0, 5'd0, 7'h67), 0);
    check("jalr_mis_illegal", 64'(illegal), 64'd1);
    check("jalr_mis_pc", pc, 64'h8000_0010);

    do_reset();
    run_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'h13), 0);
    check_reg("x0_zero", 5'd0, 64'd0);
    run_instr(32'h0010_0073, 0);
    check("ebreak_flag", 64'(flag), 64'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("halt_req_idle", 64'(imem_req), 64'd0);
      check("halt_retire_idle", 64'(retire), 64'd0);
    end

    // Reset during EXEC must discard the in-flight write
    do_reset();
    run_instr(enc_i(12'd9, 5'd0, 3'd0, 5'd1, 7'h13), 0);
    imem_rdata = enc_i(12'd7, 5'd0, 3'd0, 5'd5, 7'h13);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check("abort_pre_retire", 64'(retire), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_retire", 64'(retire), 64'd0);
    check("abort_pc", pc, RST_PC);
    check("abort_req", 64'(imem_req), 64'd1);
    check("abort_flag", 64'(flag), 64'd0);
    check("abort_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    check_reg("abort_x5", 5'd5, 64'd0);
    check_reg("abort_x1", 5'd1, 64'd0);
    rst = 1'b1;
    model_reset();

    // 16-register core: index 20 is out of range
    s_rdata = enc_i(12'd1, 5'd0, 3'd0, 5'd20, 7'h13);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    check("n16_retire", 64'(s_retire), 64'd0);
    check("n16_req", 64'(s_req), 64'd0);
    @(negedge clk);
    check("n16_illegal", 64'(s_illegal), 64'd1);
    check("n16_pc", s_pc, RST_PC);
    s_dbg_raddr = 5'd20;
    #1;
    check("n16_dbg20", s_dbg_rdata, 64'd0);
    $display("nreg16 addi x20 illegal %0b pc %h", s_illegal, s_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_mcpu.md
YSYX_22041461_MCPU -- requirements
Module: ysyx_22041461_mcpu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/register/PC width (legal values 32, 64).
REQ-002 SHALL have parameter NREG, default 32, number of integer registers (legal values 16, 32).
REQ-003 SHALL have parameter RESET_PC, default 64'h8000_0000 truncated to XLEN, PC value after reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_req  output  1  fetch request valid.
REQ-007 SHALL have port imem_addr  output  XLEN  fetch address; equals pc.
REQ-008 SHALL have port imem_ready  input  1  instruction memory accepts the request and returns data in the same cycle.
REQ-009 SHALL have port imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-010 SHALL have port pc  output  XLEN  address of the instruction being fetched or executed.
REQ-011 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-012 SHALL have port flag  output  1  sticky; set when ebreak retires.
REQ-013 SHALL have port illegal  output  1  sticky; set when an unsupported or illegal instruction is decoded.
REQ-014 SHALL have port dbg_raddr  input  5  debug register index.
REQ-015 SHALL have port dbg_rdata  output  XLEN  combinational register read; 0 for index 0 or index >= NREG.

Function
REQ-016 SHALL implement states FETCH, EXEC, HALT.
REQ-017 FETCH: SHALL drive imem_req=1; on imem_req&&imem_ready SHALL latch imem_rdata into the instruction register and enter EXEC; otherwise SHALL remain in FETCH with pc stable.
REQ-018 EXEC: SHALL last exactly one cycle, write rd, update pc, pulse retire, and return to FETCH; imem_req=0 in EXEC and HALT.
REQ-019 Minimum latency SHALL be 2 cycles per instruction (ready held high); each wait cycle in FETCH adds 1.
REQ-020 SHALL support addi, add, sub, lui, auipc, jal, jalr, ebreak; all other encodings SHALL be illegal.
REQ-021 When XLEN=64 SHALL additionally support addiw, addw, subw: 32-bit result sign-extended to 64; when XLEN=32 these encodings SHALL be illegal.
REQ-022 Immediates SHALL be sign-extended to XLEN; arithmetic SHALL wrap modulo 2^XLEN with no overflow indication.
REQ-023 Non-branch instructions SHALL set pc <= pc+4; jal SHALL set pc <= pc+imm; jalr SHALL set pc <= (rs1+imm)&~1; jal/jalr SHALL write pc+4 (old pc) into rd.
REQ-024 A jal/jalr target with bit 1 set SHALL be illegal: no rd write, pc unchanged.
REQ-025 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0.
REQ-026 With NREG=16, any rs1/rs2/rd index >= 16 SHALL be illegal.
REQ-027 jalr with rd==rs1 SHALL use the pre-write rs1 value for the target.
REQ-028 ebreak in EXEC SHALL set flag=1, pulse retire, leave pc unchanged, and enter HALT.
REQ-029 An illegal instruction in EXEC SHALL set illegal=1, write no register, not pulse retire, leave pc unchanged, and enter HALT.
REQ-030 HALT SHALL be terminal until reset; the register file SHALL remain readable via dbg port.

Reset
REQ-031 rst low SHALL asynchronously force: state FETCH, pc=RESET_PC, all registers 0, retire=0, flag=0, illegal=0.
REQ-032 imem_req SHALL become 1 once rst is deasserted.
REQ-033 Reset asserted during FETCH wait or EXEC SHALL abort the instruction; no register write and no retire from the aborted instruction.

Verification
REQ-034 Reset, then addi x1,x0,5; addi x2,x1,-7 with ready=1 -> retire every 2nd cycle; x1=5, x2=0xFFFF_FFFF_FFFF_FFFE; pc=RESET_PC+8.
REQ-035 ready low for 3 cycles on first fetch -> pc/imem_addr held at RESET_PC, retire asserted at cycle 5 after reset release.
REQ-036 jal x1,+16 at 0x8000_0000 -> x1=0x8000_0004, next imem_addr 0x8000_0010; jalr x0,2(x1) -> illegal=1, pc held.
REQ-037 XLEN=64: lui x3,0x80000; addiw x4,x3,-1 -> x3=0xFFFF_FFFF_8000_0000, x4=0x0000_0000_7FFF_FFFF.
REQ-038 ebreak -> flag=1, retire pulse, imem_req=0 thereafter; addi x0,x0,1 -> dbg_rdata(0)=0.
REQ-039 NREG=16: addi x20,x0,1 -> illegal=1, retire=0; rst pulse mid-EXEC -> all outputs at reset values.
